// File: rtl/dcache_ctrl_pkg.sv
// Shared types and defaults for the data-cache miss controller.
// Optional feature macro: DCACHE_PERF_CNT_EN (performance counters).
package dcache_ctrl_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_t;

    localparam int CNT_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk, rst_n (async low), inc, clr -> cnt[CNT_W-1:0].
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// MEM-stage data cache miss sequencer: drives and holds the cache request,
// stalls the pipe and bubbles WB for a miss, flags over-long misses.
// Ports: clk, rst_n, mem_rd/mem_wr/mem_addr, pipe_hold, cache_miss, clr_cnt
//   -> cache_rd_req/cache_wr_req/cache_addr, stall_req, bubble_w,
//      timeout_err, acc_cnt/hit_cnt/miss_cnt.
// Optional macro DCACHE_PERF_CNT_EN builds the performance counters;
// otherwise the counters read 0 and clr_cnt is ignored.
module dcache_miss_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [31:0]      mem_addr,
    input  logic             pipe_hold,
    input  logic             cache_miss,
    input  logic             clr_cnt,
    output logic             cache_rd_req,
    output logic             cache_wr_req,
    output logic [31:0]      cache_addr,
    output logic             stall_req,
    output logic             bubble_w,
    output logic             timeout_err,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state;
    state_t              state_nx;
    logic [31:0]         lat_addr;
    req_t                lat_type;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                req;
    logic                start_miss;

    assign req = mem_rd | mem_wr;

    // Outputs are gated by rst_n so requests and stall drop the moment
    // reset is asserted, not at the next edge.
    always_comb begin
        state_nx     = state;
        cache_rd_req = 1'b0;
        cache_wr_req = 1'b0;
        cache_addr   = mem_addr;
        stall_req    = 1'b0;
        start_miss   = 1'b0;
        unique case (state)
            S_IDLE: begin
                cache_rd_req = mem_rd;
                cache_wr_req = mem_wr & ~mem_rd;
                if (req && cache_miss) begin
                    stall_req  = 1'b1;
                    start_miss = 1'b1;
                    state_nx   = S_MISS;
                end
            end
            S_MISS: begin
                cache_rd_req = (lat_type == REQ_RD);
                cache_wr_req = (lat_type == REQ_WR);
                cache_addr   = lat_addr;
                stall_req    = cache_miss;
                if (!cache_miss) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (!rst_n) begin
            cache_rd_req = 1'b0;
            cache_wr_req = 1'b0;
            stall_req    = 1'b0;
            start_miss   = 1'b0;
        end
        bubble_w = stall_req;
    end

    // wait_cnt holds the number of completed MISS cycles; the error is
    // raised after TIMEOUT of them and the FSM keeps waiting regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lat_addr    <= '0;
            lat_type    <= REQ_RD;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_miss) begin
                lat_addr <= mem_addr;
                lat_type <= mem_rd ? REQ_RD : REQ_WR;
                wait_cnt <= '0;
            end else if (state == S_MISS) begin
                if (wait_cnt != WAIT_W'(TIMEOUT)) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN

    logic counted;
    logic advance;
    logic hit_inc;
    logic miss_inc;

    // counted keeps a held or re-presented instruction from being
    // counted twice; it clears only when MEM actually advances.
    assign advance  = ~pipe_hold & ~stall_req;
    assign hit_inc  = (state == S_IDLE) & req & ~cache_miss & ~counted;
    assign miss_inc = start_miss & ~counted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counted <= 1'b0;
        end else if (advance) begin
            counted <= 1'b0;
        end else if (hit_inc || miss_inc) begin
            counted <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc | miss_inc),
        .clr   (clr_cnt),
        .cnt   (acc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .clr   (clr_cnt),
        .cnt   (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .clr   (clr_cnt),
        .cnt   (miss_cnt)
    );

`else

    logic unused_cnt_in;

    assign unused_cnt_in = &{1'b0, clr_cnt, pipe_hold};
    assign acc_cnt       = '0;
    assign hit_cnt       = '0;
    assign miss_cnt      = '0;

`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed scoreboard bench for dcache_miss_ctrl (CNT_W=2, TIMEOUT=8).
// Counter expectations collapse to 0 when DCACHE_PERF_CNT_EN is undefined.
module tb_dcache_miss_ctrl;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 8;

`ifdef DCACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic        rd;
        logic        wr;
        logic        stall;
        logic        err;
        logic [31:0] addr;
        logic [1:0]  acc;
        logic [1:0]  hit;
        logic [1:0]  mis;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             mem_rd;
    logic             mem_wr;
    logic [31:0]      mem_addr;
    logic             pipe_hold;
    logic             cache_miss;
    logic             clr_cnt;
    logic             cache_rd_req;
    logic             cache_wr_req;
    logic [31:0]      cache_addr;
    logic             stall_req;
    logic             bubble_w;
    logic             timeout_err;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    dcache_miss_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .pipe_hold    (pipe_hold),
        .cache_miss   (cache_miss),
        .clr_cnt      (clr_cnt),
        .cache_rd_req (cache_rd_req),
        .cache_wr_req (cache_wr_req),
        .cache_addr   (cache_addr),
        .stall_req    (stall_req),
        .bubble_w     (bubble_w),
        .timeout_err  (timeout_err),
        .acc_cnt      (acc_cnt),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle with a pending expectation is checked mid-cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (cache_rd_req !== e.rd || cache_wr_req !== e.wr ||
                stall_req !== e.stall || bubble_w !== e.stall ||
                timeout_err !== e.err || cache_addr !== e.addr ||
                acc_cnt !== e.acc || hit_cnt !== e.hit ||
                miss_cnt !== e.mis) begin
                n_bad++;
                $display("FAIL %s: got rd=%b wr=%b stall=%b bub=%b err=%b addr=%h acc=%0d hit=%0d miss=%0d, want rd=%b wr=%b stall=%b bub=%b err=%b addr=%h acc=%0d hit=%0d miss=%0d",
                         e.nm, cache_rd_req, cache_wr_req, stall_req,
                         bubble_w, timeout_err, cache_addr, acc_cnt,
                         hit_cnt, miss_cnt, e.rd, e.wr, e.stall, e.stall,
                         e.err, e.addr, e.acc, e.hit, e.mis);
            end
        end
    end

    task automatic step(
        input string       nm,
        input logic        rstv,
        input logic        rd,
        input logic        wr,
        input logic [31:0] a,
        input logic        hold,
        input logic        miss,
        input logic        clr,
        input logic        e_rd,
        input logic        e_wr,
        input logic        e_stall,
        input logic        e_err,
        input logic [31:0] e_addr,
        input int          e_acc,
        input int          e_hit,
        input int          e_mis
    );
        exp_t e;
        rst_n      = rstv;
        mem_rd     = rd;
        mem_wr     = wr;
        mem_addr   = a;
        pipe_hold  = hold;
        cache_miss = miss;
        clr_cnt    = clr;
        e.nm    = nm;
        e.rd    = e_rd;
        e.wr    = e_wr;
        e.stall = e_stall;
        e.err   = e_err;
        e.addr  = e_addr;
        e.acc   = PERF ? 2'(e_acc) : 2'd0;
        e.hit   = PERF ? 2'(e_hit) : 2'd0;
        e.mis   = PERF ? 2'(e_mis) : 2'd0;
        q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        pipe_hold  = 1'b0;
        cache_miss = 1'b0;
        clr_cnt    = 1'b0;
        #1;

        // reset: requests and stall gated, address passes through
        step("rst0", 0, 1, 0, 32'h44, 0, 1, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0);
        step("rst1", 0, 0, 1, 32'h48, 0, 1, 0, 0, 0, 0, 0, 32'h48, 0, 0, 0);

        // hits, store, rd+wr treated as read, clear
        step("ld_hit", 1, 1, 0, 32'h10, 0, 0, 0, 1, 0, 0, 0, 32'h10, 0, 0, 0);
        step("idle1", 1, 0, 0, 32'h14, 0, 0, 0, 0, 0, 0, 0, 32'h14, 1, 1, 0);
        step("st_hit", 1, 0, 1, 32'h20, 0, 0, 0, 0, 1, 0, 0, 32'h20, 1, 1, 0);
        step("rdwr", 1, 1, 1, 32'h24, 0, 0, 0, 1, 0, 0, 0, 32'h24, 2, 2, 0);
        step("clr", 1, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 3, 3, 0);

        // load miss for 5 cycles, address held while mem_* change
        step("m_det", 1, 1, 0, 32'h100, 0, 1, 0, 1, 0, 1, 0, 32'h100, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step("m_hold", 1, 0, 1, 32'h200, 0, 1, 0,
                 1, 0, 1, 0, 32'h100, 1, 0, 1);
        step("m_rel", 1, 1, 0, 32'h100, 0, 0, 0, 1, 0, 0, 0, 32'h100, 1, 0, 1);
        step("m_idle", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1);

        // hit held by pipe_hold counts once
        for (int i = 0; i < 3; i++)
            step("h_hold", 1, 1, 0, 32'h30, 1, 0, 0,
                 1, 0, 0, 0, 32'h30, (i == 0) ? 1 : 2, (i == 0) ? 0 : 1, 1);
        step("h_go", 1, 1, 0, 32'h30, 0, 0, 0, 1, 0, 0, 0, 32'h30, 2, 1, 1);
        step("h_idle", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2, 1, 1);

        // store miss, hold in MISS and after release: no recount
        step("s_det", 1, 0, 1, 32'h40, 0, 1, 0, 0, 1, 1, 0, 32'h40, 2, 1, 1);
        step("s_miss", 1, 0, 1, 32'h40, 1, 1, 0, 0, 1, 1, 0, 32'h40, 3, 1, 2);
        step("s_rel", 1, 0, 1, 32'h40, 1, 0, 0, 0, 1, 0, 0, 32'h40, 3, 1, 2);
        step("s_rep", 1, 0, 1, 32'h40, 0, 0, 0, 0, 1, 0, 0, 32'h40, 3, 1, 2);
        step("s_idle", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 3, 1, 2);

        // back-to-back misses, no gap cycle
        step("b_det", 1, 1, 0, 32'h50, 0, 1, 0, 1, 0, 1, 0, 32'h50, 3, 1, 2);
        step("b_rel", 1, 1, 0, 32'h50, 0, 0, 0, 1, 0, 0, 0, 32'h50, 3, 1, 3);
        step("b_det2", 1, 1, 0, 32'h60, 0, 1, 0, 1, 0, 1, 0, 32'h60, 3, 1, 3);
        step("b_miss2", 1, 1, 0, 32'h99, 0, 1, 0, 1, 0, 1, 0, 32'h60, 3, 1, 3);
        step("b_rel2", 1, 0, 0, 32'h99, 0, 0, 0, 1, 0, 0, 0, 32'h60, 3, 1, 3);
        step("clr2", 1, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 3, 1, 3);

        // saturation at 3, clear beats a same-cycle hit
        for (int i = 0; i < 5; i++)
            step("sat", 1, 1, 0, 32'h1000 + 32'(4 * i), 0, 0, 0,
                 1, 0, 0, 0, 32'h1000 + 32'(4 * i),
                 (i > 3) ? 3 : i, (i > 3) ? 3 : i, 0);
        step("clr_hit", 1, 1, 0, 32'h1014, 0, 0, 1, 1, 0, 0, 0, 32'h1014, 3, 3, 0);
        step("clr_chk", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);

        // reset pulsed in the 2nd MISS cycle
        step("r_det", 1, 1, 0, 32'h70, 0, 1, 0, 1, 0, 1, 0, 32'h70, 0, 0, 0);
        step("r_miss", 1, 1, 0, 32'h70, 0, 1, 0, 1, 0, 1, 0, 32'h70, 1, 0, 1);
        step("r_rst", 0, 1, 0, 32'h70, 0, 1, 0, 0, 0, 0, 0, 32'h70, 0, 0, 0);
        step("r_idle", 1, 1, 0, 32'h74, 0, 0, 0, 1, 0, 0, 0, 32'h74, 0, 0, 0);
        step("r_cnt", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0);

        // timeout: flag appears after TIMEOUT MISS cycles and sticks
        step("t_det", 1, 0, 1, 32'h80, 0, 1, 0, 0, 1, 1, 0, 32'h80, 1, 1, 0);
        for (int j = 1; j <= TIMEOUT + 1; j++)
            step("t_wait", 1, 0, 1, 32'h80, 0, 1, 0,
                 0, 1, 1, (j > TIMEOUT), 32'h80, 2, 1, 1);
        step("t_rel", 1, 0, 1, 32'h80, 0, 0, 0, 0, 1, 0, 1, 32'h80, 2, 1, 1);
        step("t_idle", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 2, 1, 1);
        step("t_hit", 1, 1, 0, 32'h90, 0, 0, 0, 1, 0, 0, 1, 32'h90, 2, 1, 1);
        step("t_end", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 3, 2, 1);

        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
